// File: rtl/wb_pkg.sv
// Shared types and defaults for the OFM writeback controller.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    localparam int DEF_SYSTOLIC_SIZE = 16;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ACC_WIDTH     = 20;
    localparam int DEF_INOUT_WIDTH   = 128;
    localparam int DEF_NUM_FILTER    = 16;
    localparam int DEF_OFM_PIXELS    = 1024;
    localparam int DEF_ADDR_WIDTH    = 16;

    // Counter width that stays legal (>=1 bit) when the count range is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofm_writeback_ctrl_if.sv
// Accumulator-drain handshake plus OFM RAM port-B write bus.
interface ofm_writeback_ctrl_if
    import wb_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
);
    logic                                acc_valid;
    logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0]  acc_data;
    logic                                acc_ready;
    logic                                ofm_we_b;
    logic [ADDR_WIDTH-1:0]               ofm_addr_b;
    logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ofm_din_b;

    modport master (
        output acc_valid, acc_data,
        input  acc_ready, ofm_we_b, ofm_addr_b, ofm_din_b
    );

    modport slave (
        input  acc_valid, acc_data,
        output acc_ready, ofm_we_b, ofm_addr_b, ofm_din_b
    );
endinterface

// File: rtl/ofm_quant_lane.sv
// One lane of accumulator quantisation: rounding shift, optional ReLU, saturation.
module ofm_quant_lane #(
    parameter int ACC_WIDTH  = 20,
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic        [4:0]            shamt,
    input  logic                         relu_en,
    output logic signed [DATA_WIDTH-1:0] q
);
    localparam int W = ACC_WIDTH + 1;
    localparam logic signed [W-1:0] Q_MAX = W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [W-1:0] Q_MIN = -Q_MAX - W'(1);

    logic signed [W-1:0] ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] r;

    // Round-half-up shift in one extra bit so the rounding add cannot overflow;
    // very large shifts collapse to the sign of the input.
    always_comb begin
        ext = {acc[ACC_WIDTH-1], acc};
        rnd = '0;
        r   = ext;
        if (int'(shamt) >= ACC_WIDTH) begin
            r = acc[ACC_WIDTH-1] ? '1 : '0;
        end else if (shamt != 5'd0) begin
            rnd = W'(1) << (shamt - 5'd1);
            r   = (ext + rnd) >>> shamt;
        end
        if (relu_en && r[W-1]) begin
            r = '0;
        end
        if (r > Q_MAX) begin
            q = Q_MAX[DATA_WIDTH-1:0];
        end else if (r < Q_MIN) begin
            q = Q_MIN[DATA_WIDTH-1:0];
        end else begin
            q = r[DATA_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/ofm_writeback_ctrl.sv
// OFM writeback: accepts accumulator beats, quantises all lanes and writes
// one packed word per beat to a filter-major address, then pulses done.
//
// state | meaning
// IDLE  | waiting for start; captures pass configuration
// RUN   | accepting beats, one write issued per accepted beat
// FLUSH | final write in flight, no more beats accepted
// DONE  | one-cycle done pulse back to the main controller
module ofm_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int INOUT_WIDTH   = DEF_INOUT_WIDTH,
    parameter int NUM_FILTER    = DEF_NUM_FILTER,
    parameter int OFM_PIXELS    = DEF_OFM_PIXELS,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  relu_en,
    input  logic [4:0]            shamt,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    ofm_writeback_ctrl_if.slave   bus,
    output logic                  busy,
    output logic                  done
);
    localparam int TILES = OFM_PIXELS / SYSTOLIC_SIZE;
    localparam int FW    = cnt_width(NUM_FILTER);
    localparam int TW    = cnt_width(TILES);

    if (INOUT_WIDTH != SYSTOLIC_SIZE * DATA_WIDTH) begin : g_bad_inout_width
        $error("INOUT_WIDTH must equal SYSTOLIC_SIZE*DATA_WIDTH");
    end
    if (OFM_PIXELS % SYSTOLIC_SIZE != 0) begin : g_bad_ofm_pixels
        $error("OFM_PIXELS must be a multiple of SYSTOLIC_SIZE");
    end

    wb_state_t             state, state_nxt;
    logic [FW-1:0]         cnt_f;
    logic [TW-1:0]         cnt_t;
    logic                  relu_q;
    logic [4:0]            shamt_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  acc_ready;
    logic                  hs;
    logic                  last_f;
    logic                  last_t;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [INOUT_WIDTH-1:0] q_word;

    assign hs      = bus.acc_valid && acc_ready;
    assign last_f  = (cnt_f == FW'(NUM_FILTER - 1));
    assign last_t  = (cnt_t == TW'(TILES - 1));
    assign wr_addr = base_q + ADDR_WIDTH'(cnt_f) * ADDR_WIDTH'(TILES) + ADDR_WIDTH'(cnt_t);

    assign bus.acc_ready = acc_ready;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_lane
        ofm_quant_lane #(
            .ACC_WIDTH  (ACC_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .acc     (bus.acc_data[i*ACC_WIDTH +: ACC_WIDTH]),
            .shamt   (shamt_q),
            .relu_en (relu_q),
            .q       (q_word[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        acc_ready = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                acc_ready = 1'b1;
                if (hs && last_f && last_t) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Pass configuration capture and filter-fastest beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_f   <= '0;
            cnt_t   <= '0;
            relu_q  <= 1'b0;
            shamt_q <= '0;
            base_q  <= '0;
        end else if (state == IDLE && start) begin
            cnt_f   <= '0;
            cnt_t   <= '0;
            relu_q  <= relu_en;
            shamt_q <= shamt;
            base_q  <= base_addr;
        end else if (hs) begin
            if (last_f) begin
                cnt_f <= '0;
                cnt_t <= cnt_t + TW'(1);
            end else begin
                cnt_f <= cnt_f + FW'(1);
            end
        end
    end

    // Write stage: one registered write per accepted beat; address/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ofm_we_b   <= 1'b0;
            bus.ofm_addr_b <= '0;
            bus.ofm_din_b  <= '0;
        end else begin
            bus.ofm_we_b <= hs;
            if (hs) begin
                bus.ofm_addr_b <= wr_addr;
                bus.ofm_din_b  <= q_word;
            end
        end
    end
endmodule

// File: tb/tb_ofm_writeback_ctrl.sv
// Directed bench for ofm_writeback_ctrl: default instance plus a small
// two-filter instance for address wrap.
module tb_ofm_writeback_ctrl;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_s;
    logic        relu_en;
    logic [4:0]  shamt;
    logic [15:0] base_addr, base_s;
    logic        busy, done, busy_s, done_s;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int lane_in  [16];
    int lane_exp [16];

    always #5 clk = ~clk;

    ofm_writeback_ctrl_if ifc ();
    ofm_writeback_ctrl_if ifc_s ();

    ofm_writeback_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en), .shamt(shamt),
        .base_addr(base_addr), .bus(ifc), .busy(busy), .done(done)
    );

    ofm_writeback_ctrl #(.NUM_FILTER(2), .OFM_PIXELS(32)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .relu_en(relu_en), .shamt(shamt),
        .base_addr(base_s), .bus(ifc_s), .busy(busy_s), .done(done_s)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat (or an idle cycle), clock it, then check the write port.
    task automatic step(input bit sel, input logic v, input logic [319:0] d,
                        input logic [15:0] ea, input logic [127:0] ew,
                        input string tag, output logic hs);
        logic        we;
        logic [15:0] a;
        logic [127:0] w;
        if (sel) begin
            ifc_s.acc_valid = v; ifc_s.acc_data = d; hs = v && ifc_s.acc_ready;
        end else begin
            ifc.acc_valid = v; ifc.acc_data = d; hs = v && ifc.acc_ready;
        end
        @(posedge clk); #1;
        if (sel) begin
            we = ifc_s.ofm_we_b; a = ifc_s.ofm_addr_b; w = ifc_s.ofm_din_b; ifc_s.acc_valid = 1'b0;
        end else begin
            we = ifc.ofm_we_b; a = ifc.ofm_addr_b; w = ifc.ofm_din_b; ifc.acc_valid = 1'b0;
        end
        if (we === 1'b1) wr_cnt++;
        check({tag, "_we"}, 128'(we), 128'(hs));
        if (hs) begin
            check({tag, "_addr"}, 128'(a), 128'(ea));
            check({tag, "_din"}, w, ew);
        end
    endtask

    function automatic logic [319:0] rep_acc(input int v);
        return {16{20'(v)}};
    endfunction

    function automatic logic [127:0] rep_q(input int v);
        return {16{8'(v)}};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < 16; i++) begin
            lane_in[i] = 0; lane_exp[i] = 0;
        end
    endtask

    // One-beat pass with the lane tables, then abort it with reset.
    task automatic quant_case(input logic [4:0] sh, input logic rl, input string tag);
        logic [319:0] d;
        logic [127:0] ew;
        logic hs;
        for (int i = 0; i < 16; i++) begin
            d[i*20 +: 20] = 20'(lane_in[i]);
            ew[i*8 +: 8]  = 8'(lane_exp[i]);
        end
        shamt = sh; relu_en = rl; base_addr = 16'h0000;
        pulse_start();
        step(1'b0, 1'b1, d, 16'h0000, ew, tag, hs);
        pulse_reset();
    endtask

    // Checks the FLUSH -> DONE -> IDLE tail after the last accepted beat.
    task automatic check_tail(input bit sel, input string tag);
        check({tag, "_flush_done"}, 128'(sel ? done_s : done), 128'(0));
        check({tag, "_flush_busy"}, 128'(sel ? busy_s : busy), 128'(1));
        @(posedge clk); #1;
        check({tag, "_done"}, 128'(sel ? done_s : done), 128'(1));
        check({tag, "_done_we"}, 128'(sel ? ifc_s.ofm_we_b : ifc.ofm_we_b), 128'(0));
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 128'(sel ? done_s : done), 128'(0));
        check({tag, "_idle_busy"}, 128'(sel ? busy_s : busy), 128'(0));
    endtask

    initial begin
        logic hs;
        int   q, guard;
        logic [15:0] small_addr [4];
        small_addr[0] = 16'hFFFE; small_addr[1] = 16'h0000;
        small_addr[2] = 16'hFFFF; small_addr[3] = 16'h0001;

        rst_n = 1'b0; start = 1'b0; start_s = 1'b0; relu_en = 1'b0; shamt = 5'd0;
        base_addr = '0; base_s = '0;
        ifc.acc_valid = 1'b0; ifc.acc_data = '0;
        ifc_s.acc_valid = 1'b0; ifc_s.acc_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 128'(ifc.ofm_we_b), 128'(0));
        check("rst_addr", 128'(ifc.ofm_addr_b), 128'(0));
        check("rst_din", ifc.ofm_din_b, 128'(0));
        check("rst_ready", 128'(ifc.acc_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-pass aborts; restart begins again at base_addr.
        shamt = 5'd4; relu_en = 1'b0; base_addr = 16'h0100;
        pulse_start();
        check("mid_busy", 128'(busy), 128'(1));
        for (int b = 0; b < 5; b++)
            step(1'b0, 1'b1, rep_acc(16 * b), 16'(16'h0100 + 64 * b), rep_q(b), "mid", hs);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 128'(ifc.ofm_we_b), 128'(0));
        check("mid_rst_addr", 128'(ifc.ofm_addr_b), 128'(0));
        check("mid_rst_din", ifc.ofm_din_b, 128'(0));
        check("mid_rst_ready", 128'(ifc.acc_ready), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("mid_no_done", 128'(done), 128'(0));
        end
        pulse_start();
        step(1'b0, 1'b1, rep_acc(0), 16'h0100, rep_q(0), "restart", hs);
        pulse_reset();

        // Quantisation corners.
        clear_lanes();
        lane_in[0] = 1000;  lane_in[1] = -1000; lane_in[2] = 8;
        lane_in[3] = 7;     lane_in[4] = 2047;  lane_in[5] = -2049;
        lane_exp[0] = 63;   lane_exp[1] = -62;  lane_exp[2] = 1;
        lane_exp[3] = 0;    lane_exp[4] = 127;  lane_exp[5] = -128;
        quant_case(5'd4, 1'b0, "q_sh4");
        lane_exp[1] = 0; lane_exp[5] = 0;
        quant_case(5'd4, 1'b1, "q_sh4_relu");
        clear_lanes();
        lane_in[0] = 5;  lane_in[1] = -5;  lane_in[3] = 524287; lane_in[4] = -524288;
        lane_exp[1] = -1; lane_exp[4] = -1;
        quant_case(5'd20, 1'b0, "q_sh20");
        clear_lanes();
        lane_in[0] = -5; lane_in[1] = 5;
        quant_case(5'd31, 1'b1, "q_sh31_relu");
        clear_lanes();
        lane_in[0] = 100; lane_in[1] = 300;  lane_in[2] = -300;
        lane_in[3] = -128; lane_in[4] = 127; lane_in[5] = -129;
        lane_exp[0] = 100; lane_exp[1] = 127; lane_exp[2] = -128;
        lane_exp[3] = -128; lane_exp[4] = 127; lane_exp[5] = -128;
        quant_case(5'd0, 1'b0, "q_sh0");

        // Full pass with a start pulse in RUN that must be ignored.
        shamt = 5'd4; relu_en = 1'b0; base_addr = 16'h0000;
        pulse_start();
        wr_cnt = 0;
        for (int t = 0; t < 64; t++) begin
            for (int f = 0; f < 16; f++) begin
                if (t == 0 && f == 10) begin
                    start = 1'b1; base_addr = 16'h4000;
                end
                q = (16 * f + t + 8) / 16;
                step(1'b0, 1'b1, rep_acc(16 * f + t), 16'(64 * f + t), rep_q(q), "full", hs);
                start = 1'b0;
                if (t == 3 && f == 5) check("full_t3f5_addr", 128'(ifc.ofm_addr_b), 128'(323));
            end
        end
        check_tail(1'b0, "full");
        check("full_writes", 128'(wr_cnt), 128'(1024));

        // Same pass under random back-pressure.
        base_addr = 16'h0000;
        pulse_start();
        wr_cnt = 0;
        for (int t = 0; t < 64; t++) begin
            for (int f = 0; f < 16; f++) begin
                q = (16 * f + t + 8) / 16;
                hs = 1'b0;
                guard = 0;
                while (!hs && guard < 64) begin
                    step(1'b0, 1'($urandom_range(0, 1)), rep_acc(16 * f + t),
                         16'(64 * f + t), rep_q(q), "bp", hs);
                    guard++;
                end
                if (!hs) check("bp_stall_timeout", 128'(hs), 128'(1));
            end
        end
        check_tail(1'b0, "bp");
        check("bp_writes", 128'(wr_cnt), 128'(1024));

        // Small configuration: two filters, two tiles, address wrap.
        shamt = 5'd0; relu_en = 1'b0; base_s = 16'hFFFE;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int b = 0; b < 4; b++) begin
            logic [319:0] d;
            logic [127:0] ew;
            for (int i = 0; i < 16; i++) begin
                d[i*20 +: 20] = 20'(b * 10 + i);
                ew[i*8 +: 8]  = 8'(b * 10 + i);
            end
            step(1'b1, 1'b1, d, small_addr[b], ew, "small", hs);
        end
        check_tail(1'b1, "small");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
